// File: rtl/student_circuit_pkg.sv
// Shared types and constants for the registered student data-transform block.
package student_circuit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] KIND_PASS = 2'b00;
  localparam logic [1:0] KIND_INV  = 2'b01;
  localparam logic [1:0] KIND_POP  = 2'b10;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/student_circuit_seq_popcount_chunk.sv
// Combinational population count of an N-bit slice.
module popcount_chunk
  import student_circuit_pkg::*;
#(
  parameter int N = 2,
  localparam int CW = clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++)
      count = count + CW'(bits[i]);
  end

endmodule

// File: rtl/student_circuit_seq.sv
// Registered classify-and-transform unit: invert, iterative popcount or pass.
module student_circuit_seq
  import student_circuit_pkg::*;
#(
  parameter int          WIDTH          = 8,
  parameter int          BITS_PER_CYCLE = 2,
  parameter logic [3:0]  MATCH_NIBBLE   = 4'b0011
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_kind,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int AW    = clog2(WIDTH + 1);
  localparam int CW    = clog2(BITS_PER_CYCLE + 1);
  localparam int SW    = clog2(STEPS + 1);

  state_t           state;
  logic [WIDTH-1:0] shift;
  logic [AW-1:0]    acc;
  logic [SW-1:0]    step;
  logic [CW-1:0]    chunk;
  logic [AW-1:0]    acc_nxt;
  logic             is_inv;
  logic             is_pop;

  popcount_chunk #(.N(BITS_PER_CYCLE)) u_chunk (
    .bits  (shift[BITS_PER_CYCLE-1:0]),
    .count (chunk)
  );

  assign acc_nxt  = acc + AW'(chunk);
  assign is_inv   = in_data[WIDTH-1:WIDTH-4] == MATCH_NIBBLE;
  assign is_pop   = in_data[WIDTH-1];
  assign in_ready = state == IDLE;
  assign busy     = state != IDLE;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      shift     <= '0;
      acc       <= '0;
      step      <= '0;
      out_data  <= '0;
      out_kind  <= KIND_PASS;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            shift <= in_data;
            acc   <= '0;
            step  <= '0;
            // Nibble match outranks the MSB popcount trigger.
            priority case (1'b1)
              is_inv: begin
                out_data  <= ~in_data;
                out_kind  <= KIND_INV;
                out_valid <= 1'b1;
                state     <= HOLD;
              end
              is_pop: begin
                state <= COUNT;
              end
              default: begin
                out_data  <= in_data;
                out_kind  <= KIND_PASS;
                out_valid <= 1'b1;
                state     <= HOLD;
              end
            endcase
          end
        end
        COUNT: begin
          acc   <= acc_nxt;
          shift <= shift >> BITS_PER_CYCLE;
          step  <= step + 1'b1;
          if (step == SW'(STEPS - 1)) begin
            out_data  <= WIDTH'(acc_nxt);
            out_kind  <= KIND_POP;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_student_circuit_seq.sv
// Bench for student_circuit_seq at WIDTH=8/BPC=2 and WIDTH=16/BPC=4.
module tb_student_circuit_seq;

  typedef struct {
    bit          w16;
    logic [15:0] din;
    logic [15:0] dout;
    logic [1:0]  kind;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        clear;
  logic [7:0]  in8, od8;
  logic        iv8, ir8, ov8, or8, bz8;
  logic [1:0]  ok8;
  logic [15:0] in16, od16;
  logic        iv16, ir16, ov16, or16, bz16;
  logic [1:0]  ok16;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  student_circuit_seq #(.WIDTH(8), .BITS_PER_CYCLE(2)) dut8 (
    .clk(clk), .clear(clear),
    .in_data(in8), .in_valid(iv8), .in_ready(ir8),
    .out_data(od8), .out_kind(ok8), .out_valid(ov8),
    .out_ready(or8), .busy(bz8)
  );

  student_circuit_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .clear(clear),
    .in_data(in16), .in_valid(iv16), .in_ready(ir16),
    .out_data(od16), .out_kind(ok16), .out_valid(ov16),
    .out_ready(or16), .busy(bz16)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] g_od(bit w);
    return w ? od16 : {8'h00, od8};
  endfunction
  function automatic logic [1:0] g_ok(bit w);
    return w ? ok16 : ok8;
  endfunction
  function automatic logic g_ov(bit w);
    return w ? ov16 : ov8;
  endfunction
  function automatic logic g_ir(bit w);
    return w ? ir16 : ir8;
  endfunction
  function automatic logic g_bz(bit w);
    return w ? bz16 : bz8;
  endfunction

  task automatic put_in(bit w, logic [15:0] d, logic v);
    if (w) begin in16 = d; iv16 = v; end
    else begin in8 = d[7:0]; iv8 = v; end
  endtask

  task automatic put_or(bit w, logic v);
    if (w) or16 = v;
    else or8 = v;
  endtask

  task automatic run_vec(vec_t v);
    int lat;
    bit done;
    logic [15:0] prev;
    vec_t e;
    @(negedge clk);
    chk("in_ready_idle", g_ir(v.w16), 1);
    prev = g_od(v.w16);
    put_in(v.w16, v.din, 1'b1);
    sb.push_back(v);
    @(posedge clk);
    #1 put_in(v.w16, 16'h0, 1'b0);
    lat = 0;
    done = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (g_ov(v.w16)) done = 1;
      else if (lat == 2) begin
        chk("busy_count", g_bz(v.w16), 1);
        chk("in_ready_count", g_ir(v.w16), 0);
        chk("out_data_frozen", g_od(v.w16), prev);
      end
    end
    e = sb.pop_front();
    if (!done) chk("out_valid_timeout", 0, 1);
    else begin
      chk("latency", lat, e.lat);
      chk("out_data", g_od(v.w16), e.dout);
      chk("out_kind", g_ok(v.w16), e.kind);
    end
    put_or(v.w16, 1'b1);
    @(posedge clk);
    #1 put_or(v.w16, 1'b0);
    chk("out_valid_drop", g_ov(v.w16), 0);
    chk("in_ready_back", g_ir(v.w16), 1);
  endtask

  initial begin
    vec_t e;
    clear = 1'b1;
    in8 = '0; iv8 = 0; or8 = 0;
    in16 = '0; iv16 = 0; or16 = 0;

    vecs.push_back('{0, 16'h0035, 16'h00CA, 2'b01, 1});
    vecs.push_back('{0, 16'h00B7, 16'h0006, 2'b10, 5});
    vecs.push_back('{0, 16'h005A, 16'h005A, 2'b00, 1});
    vecs.push_back('{0, 16'h0080, 16'h0001, 2'b10, 5});
    vecs.push_back('{0, 16'h00FF, 16'h0008, 2'b10, 5});
    vecs.push_back('{0, 16'h0000, 16'h0000, 2'b00, 1});
    vecs.push_back('{1, 16'hFFFF, 16'h0010, 2'b10, 5});
    vecs.push_back('{1, 16'h3ABC, 16'hC543, 2'b01, 1});
    vecs.push_back('{1, 16'h8001, 16'h0002, 2'b10, 5});
    vecs.push_back('{1, 16'h1234, 16'h1234, 2'b00, 1});

    #12;
    chk("rst_out_valid", ov8, 0);
    chk("rst_out_data", od8, 0);
    chk("rst_out_kind", ok8, 0);
    chk("rst_busy", bz8, 0);
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid16", ov16, 0);
    clear = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held while out_ready is low, new input ignored.
    @(negedge clk);
    put_in(0, 16'h0035, 1'b1);
    sb.push_back('{0, 16'h0035, 16'h00CA, 2'b01, 1});
    @(posedge clk);
    #1 put_in(0, 16'h0, 1'b0);
    @(negedge clk);
    e = sb.pop_front();
    chk("bp_valid", ov8, 1);
    chk("bp_data", od8, e.dout[7:0]);
    chk("bp_kind", ok8, e.kind);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) iv8 = 1'b0;
      chk("bp_hold_valid", ov8, 1);
      chk("bp_hold_data", od8, 8'hCA);
      chk("bp_hold_in_ready", ir8, 0);
      if (i == 1) begin in8 = 8'h11; iv8 = 1'b1; end
    end
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    chk("bp_release_ready", ir8, 1);
    chk("bp_release_valid", ov8, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_ignored_valid", ov8, 0);
      chk("bp_ignored_busy", bz8, 0);
    end

    // Async clear in the second COUNT cycle discards the popcount.
    @(negedge clk);
    in8 = 8'hFF;
    iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    @(posedge clk);
    #3 clear = 1'b1;
    #1;
    chk("clr_out_valid", ov8, 0);
    chk("clr_out_data", od8, 0);
    chk("clr_out_kind", ok8, 0);
    chk("clr_busy", bz8, 0);
    chk("clr_in_ready", ir8, 1);
    #2 clear = 1'b0;
    run_vec('{0, 16'h000F, 16'h000F, 2'b00, 1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/student_circuit_seq.md
Name: student_circuit_seq

Overview:
Parametrised, registered successor to the combinational student data-transform circuit.
- Each accepted word is classified, then one of three operations is applied: invert, population count, or pass-through.
- Popcount is computed iteratively, BITS_PER_CYCLE bits per clock, trading latency for area.
- Sits between a valid/ready producer and a valid/ready consumer in lab datapaths.

Parameters:
WIDTH, 8, data width; multiple of 4, >= 8
BITS_PER_CYCLE, 2, bits counted per COUNT cycle; must divide WIDTH
MATCH_NIBBLE, 4'b0011, value of in_data[WIDTH-1:WIDTH-4] that selects the invert operation

Ports:
clk  input  1  single clock, rising edge
clear  input  1  asynchronous, active-high reset
in_data  input  WIDTH  operand
in_valid  input  1  producer has operand
in_ready  output  1  block can accept; high only in IDLE
out_data  output  WIDTH  result
out_kind  output  2  operation applied: 00 pass, 01 invert, 10 popcount
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
busy  output  1  state != IDLE

Behaviour:
- Reset (clear=1, async): state=IDLE; out_data=0, out_kind=00, out_valid=0, busy=0, in_ready=1 on release. Accumulator and bit counter are cleared. A clear mid-COUNT or mid-HOLD discards the operation silently.
- States: IDLE, COUNT, HOLD.
- IDLE: in_ready=1. Accept on the edge where in_valid=1. Operand is captured into a shift register.
- Classification is fixed at accept, priority order:
  1. in_data[WIDTH-1:WIDTH-4]==MATCH_NIBBLE -> invert. Match wins even if the MSB is also set.
  2. in_data[WIDTH-1]==1 -> popcount.
  3. Otherwise -> pass.
- Invert and pass: out_data = ~in_data or in_data, loaded at the accept edge. Go to HOLD. out_valid=1 the cycle after accept (latency 1).
- Popcount:
  - Go to COUNT. Accumulator is zeroed at the accept edge.
  - Each COUNT edge: acc += popcount(shift[BITS_PER_CYCLE-1:0]); shift >>= BITS_PER_CYCLE.
  - After N=WIDTH/BITS_PER_CYCLE COUNT edges, out_data = acc zero-extended to WIDTH (acc width clog2(WIDTH+1)). Go to HOLD.
  - Total latency from accept edge to out_valid: N+1 cycles. With defaults, N=4, so 5 cycles.
  - out_data and out_kind do not change during COUNT. Only the internal accumulator moves.
- HOLD:
  - out_valid=1. out_data and out_kind are stable while out_ready=0.
  - On an edge with out_ready=1, out_valid drops and the state returns to IDLE.
  - No same-cycle re-accept. Maximum throughput is 1 word per 2 cycles for pass/invert.
- in_valid while busy is ignored. The producer must hold it until in_ready.
- out_ready in IDLE or COUNT has no effect.
- Result range: popcount max = WIDTH; accumulator must not wrap (WIDTH=8 -> 0x08).

Decomposition:
- Package student_circuit_pkg:
  - state encoding constants: IDLE, COUNT, HOLD.
  - out_kind constants: KIND_PASS=2'b00, KIND_INV=2'b01, KIND_POP=2'b10.
  - clog2 function.
- Sub-module popcount_chunk (parameter N=BITS_PER_CYCLE): combinational count of N bits, output clog2(N+1) bits. Instantiated once in the COUNT datapath.

Test Plan:
- WIDTH=8, in_data=0x35 accepted -> next cycle out_valid=1, out_data=0xCA, out_kind=01; out_ready=1 -> IDLE, in_ready=1 following cycle.
- in_data=0xB7 -> busy for COUNT cycles, in_ready=0; out_valid rises 5 cycles after accept with out_data=0x06, out_kind=10.
- in_data=0x5A -> out_data=0x5A, out_kind=00, latency 1; in_data=0x80 -> popcount 0x01.
- Backpressure: after 0x35, hold out_ready=0 for 3 cycles -> out_data=0xCA and out_valid=1 stable, in_ready=0, a pulsed in_valid=0x11 is ignored; then out_ready=1 -> IDLE.
- clear asserted asynchronously in 2nd COUNT cycle of 0xFF -> outputs zero immediately, IDLE; next accept of 0x0F passes 0x0F unaffected.
- WIDTH=16, BITS_PER_CYCLE=4: 0xFFFF -> out_data=0x0010 after 5 cycles; 0x3ABC -> invert 0xC543 after 1 cycle.
